// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: imem request/response channel plus IF/ID output.
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_prefetch_queue_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [PC_W-1:0]  imem_req_addr;
    logic             imem_rsp_valid;
    logic [INS_W-1:0] imem_rsp_data;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [INS_W-1:0] out_instr;

    modport master (
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential fetch address generator with in-order prefetch queue.
// Define FETCH_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module fetch_prefetch_queue #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    // Extra headroom: stale requests may pile up across repeated redirects.
    localparam int CW   = AW + 4;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  q_pc    [DEPTH];
    logic [INS_W-1:0] q_instr [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNTW-1:0]  count;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    discard;
    // PCs of live (non-discarded) requests, in issue order.
    logic [PC_W-1:0]  pf_pc   [DEPTH];
    logic [AW-1:0]    pf_rd;
    logic [AW-1:0]    pf_wr;

    logic          req_fire;
    logic          rsp_live;
    logic          head_valid;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [CW-1:0] credit_used;

    // Credit check, handshake qualification and output selection.
    always_comb begin
        credit_used = CW'(count) + outstanding - discard;
        bus.imem_req_valid = !reset && !bus.redirect
                             && (credit_used < CW'(DEPTH));
        bus.imem_req_addr = fetch_pc;
        req_fire = bus.imem_req_valid && bus.imem_req_ready;
        rsp_live = bus.imem_rsp_valid && (discard == '0) && !bus.redirect;
        head_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass = !reset && !head_valid && rsp_live;
`else
        bypass = 1'b0;
`endif
        bus.out_valid = head_valid || bypass;
        bus.out_pc    = '0;
        bus.out_instr = '0;
        if (head_valid) begin
            bus.out_pc    = q_pc[rd_ptr];
            bus.out_instr = q_instr[rd_ptr];
        end else if (bypass) begin
            bus.out_pc    = pf_pc[pf_rd];
            bus.out_instr = bus.imem_rsp_data;
        end
        pop  = head_valid && bus.out_ready && !bus.redirect;
        push = rsp_live && !(bypass && bus.out_ready);
    end

    // Pointers, counters and fetch PC; redirect flushes everything live.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            pf_rd       <= '0;
            pf_wr       <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire)
                           - CW'(bus.imem_rsp_valid);
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc & ~PC_W'(3);
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                pf_rd    <= '0;
                pf_wr    <= '0;
                discard  <= outstanding - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_W'(4);
                    pf_wr    <= pf_wr + AW'(1);
                end
                if (bus.imem_rsp_valid && (discard != '0))
                    discard <= discard - CW'(1);
                if (rsp_live)
                    pf_rd <= pf_rd + AW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CNTW'(push) - CNTW'(pop);
            end
        end
    end

    // Storage arrays: request PCs on issue, {pc, instr} on response.
    always_ff @(posedge clk) begin
        if (req_fire)
            pf_pc[pf_wr] <= fetch_pc;
        if (push) begin
            q_pc[wr_ptr]    <= pf_pc[pf_rd];
            q_instr[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order variable-latency imem model.
// Expected values adjust for FETCH_BYPASS_EN when defined.
module tb_fetch_prefetch_queue;
    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

    fetch_prefetch_queue #(
        .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- imem model ----------------
    int lat   = 1;
    int cyc   = 0;
    int n_req = 0;
    logic [PC_W-1:0] mq_addr[$];
    int              mq_due[$];
    bit              m_hs;
    bit              m_took;
    logic [PC_W-1:0] m_addr;

    function automatic logic [INS_W-1:0] idata(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
    end

    always @(posedge clk) begin
        m_hs   = bus.imem_req_valid && bus.imem_req_ready;
        m_took = bus.imem_rsp_valid;
        m_addr = bus.imem_req_addr;
        cyc++;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (m_took && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (m_hs) begin
                mq_addr.push_back(m_addr);
                mq_due.push_back(cyc + lat - 1);
                n_req++;
            end
        end
        #1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = idata(mq_addr[0]);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic do_reset(input int l, input logic ordy);
        reset = 1'b1;
        lat = l;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = ordy;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        lat = 1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid got %b want 0", bus.imem_req_valid);
        end
        n_checks++;
        if (bus.imem_req_addr !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_req_addr got %h want 000", bus.imem_req_addr);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_pc !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_out_pc got %h want 000", bus.out_pc);
        end
        n_checks++;
        if (bus.out_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_instr got %h want 0", bus.out_instr);
        end
    endtask

    task automatic test_stream;
        logic [PC_W-1:0] e;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 9'h000) begin
            n_fail++;
            $display("FAIL stream_first_req got v=%b a=%h want v=1 a=000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== BYP) begin
            n_fail++;
            $display("FAIL stream_early_valid got %b want %b", bus.out_valid, BYP);
        end
        n_checks++;
        if (bus.imem_req_addr !== 9'h004) begin
            n_fail++;
            $display("FAIL stream_second_addr got %h want 004", bus.imem_req_addr);
        end
        if (!BYP) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            e = PC_W'(4 * k);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== e) begin
                n_fail++;
                $display("FAIL stream_pc[%0d] got v=%b pc=%h want v=1 pc=%h",
                         k, bus.out_valid, bus.out_pc, e);
            end
            n_checks++;
            if (bus.out_instr !== idata(e)) begin
                n_fail++;
                $display("FAIL stream_instr[%0d] got %h want %h",
                         k, bus.out_instr, idata(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        int n0;
        int got;
        logic [PC_W-1:0] e;
        do_reset(1, 1'b0);
        n0 = n_req;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_req - n0 != 4) begin
            n_fail++;
            $display("FAIL stall_req_count got %0d want 4", n_req - n0);
        end
        n_checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 9'h010) begin
            n_fail++;
            $display("FAIL stall_req got v=%b a=%h want v=0 a=010",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 9'h000) begin
            n_fail++;
            $display("FAIL stall_head got v=%b pc=%h want v=1 pc=000",
                     bus.out_valid, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (bus.out_valid) begin
                e = PC_W'(4 * got);
                n_checks++;
                if (bus.out_pc !== e || bus.out_instr !== idata(e)) begin
                    n_fail++;
                    $display("FAIL stall_release[%0d] got pc=%h ins=%h want pc=%h",
                             got, bus.out_pc, bus.out_instr, e);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL stall_timeout got %0d outputs want 8", got);
        end
    endtask

    task automatic test_redirect_inflight;
        int got;
        logic [PC_W-1:0] e;
        do_reset(3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 9'h083;
        #1;
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_req_blocked got %b want 0", bus.imem_req_valid);
        end
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 9'h080) begin
            n_fail++;
            $display("FAIL redir_new_req got v=%b a=%h want v=1 a=080",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flushed got %b want 0", bus.out_valid);
        end
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (bus.out_valid) begin
                e = PC_W'(9'h080 + 4 * got);
                n_checks++;
                if (bus.out_pc !== e || bus.out_instr !== idata(e)) begin
                    n_fail++;
                    $display("FAIL redir_out[%0d] got pc=%h ins=%h want pc=%h",
                             got, bus.out_pc, bus.out_instr, e);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL redir_timeout got %0d outputs want 3", got);
        end
    endtask

    task automatic test_redirect_collide;
        int got;
        logic [PC_W-1:0] e;
        do_reset(2, 1'b1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_pre_valid got %b want 1", bus.out_valid);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 9'h040;
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_empty got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.imem_req_addr !== 9'h040) begin
            n_fail++;
            $display("FAIL collide_addr got %h want 040", bus.imem_req_addr);
        end
        got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            if (bus.out_valid) begin
                e = PC_W'(9'h040 + 4 * got);
                n_checks++;
                if (bus.out_pc !== e) begin
                    n_fail++;
                    $display("FAIL collide_out[%0d] got %h want %h",
                             got, bus.out_pc, e);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL collide_timeout got %0d outputs want 2", got);
        end
    endtask

    task automatic test_wrap;
        int got;
        logic [PC_W-1:0] e;
        lat = 1;
        bus.out_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 9'h1F8;
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        n_checks++;
        if (bus.imem_req_addr !== 9'h1F8) begin
            n_fail++;
            $display("FAIL wrap_addr got %h want 1f8", bus.imem_req_addr);
        end
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (bus.out_valid) begin
                e = 9'h1F8 + PC_W'(4 * got);
                n_checks++;
                if (bus.out_pc !== e || bus.out_instr !== idata(e)) begin
                    n_fail++;
                    $display("FAIL wrap_out[%0d] got pc=%h ins=%h want pc=%h",
                             got, bus.out_pc, bus.out_instr, e);
                end
                got++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL wrap_timeout got %0d outputs want 4", got);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        do_reset(1, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_valid got %b want 1", bus.out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 9'h000) begin
            n_fail++;
            $display("FAIL midrst_out got v=%b pc=%h want v=0 pc=000",
                     bus.out_valid, bus.out_pc);
        end
        n_checks++;
        if (bus.imem_req_addr !== 9'h000 || bus.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_req got v=%b a=%h want v=0 a=000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        reset = 1'b0;
        n0 = n_req;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_req - n0 != 4) begin
            n_fail++;
            $display("FAIL midrst_credits got %0d want 4", n_req - n0);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 9'h000) begin
            n_fail++;
            $display("FAIL midrst_head got v=%b pc=%h want v=1 pc=000",
                     bus.out_valid, bus.out_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
